// File: rtl/impulse_pkg.sv
// Shared definitions for the voice/envelope datapath.
//   env_state_t  : envelope state encoding, also exported on env_adsr.state
//   ENV_LVL_W    : envelope level accumulator width
//   ENV_LVL_MAX  : full-scale level (all ones)
//   sat_add/sat_sub : saturating level arithmetic at ENV_LVL_W bits
package impulse_pkg;

    localparam int unsigned ENV_LVL_W = 23;
    localparam logic [ENV_LVL_W-1:0] ENV_LVL_MAX = '1;

    typedef enum logic [2:0] {
        ENV_IDLE,
        ENV_ATTACK,
        ENV_DECAY,
        ENV_SUSTAIN,
        ENV_RELEASE
    } env_state_t;

    // Clamp to full scale instead of wrapping.
    function automatic logic [ENV_LVL_W-1:0] sat_add(input logic [ENV_LVL_W-1:0] a,
                                                     input logic [ENV_LVL_W-1:0] b);
        logic [ENV_LVL_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[ENV_LVL_W] ? ENV_LVL_MAX : s[ENV_LVL_W-1:0];
    endfunction

    // Clamp to zero instead of wrapping.
    function automatic logic [ENV_LVL_W-1:0] sat_sub(input logic [ENV_LVL_W-1:0] a,
                                                     input logic [ENV_LVL_W-1:0] b);
        logic [ENV_LVL_W:0] d;
        d = {1'b0, a} - {1'b0, b};
        return d[ENV_LVL_W] ? '0 : d[ENV_LVL_W-1:0];
    endfunction

endpackage

// File: rtl/env_adsr.sv
// ADSR envelope generator, one per oscillator voice.
// Level advances only on sampleTick; volume = {2'b00, level[LVL_W-1 -: 15]}.
// Ports:
//   clk, rst (async, active-low)
//   sampleTick   one-clk strobe per audio sample
//   en           voice enable; low forces IDLE and level 0
//   gate         note held / released, sampled on ticks only
//   attackRate, decayRate, releaseRate  per-tick step sizes (0 = instantaneous)
//   sustainLevel 15-bit sustain volume
//   volume       17-bit signed, never negative
//   active       high while state != IDLE
//   state        current env_state_t
// Build option: ENV_EXP_RELEASE_EN selects an exponential release tail,
// decrement = (level >> releaseRate[3:0]) + 1; otherwise linear by releaseRate.
module env_adsr
    import impulse_pkg::*;
#(
    parameter int unsigned LVL_W = ENV_LVL_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sampleTick,
    input  logic        en,
    input  logic        gate,
    input  logic [15:0] attackRate,
    input  logic [15:0] decayRate,
    input  logic [14:0] sustainLevel,
    input  logic [15:0] releaseRate,
    output logic [16:0] volume,
    output logic        active,
    output logic [2:0]  state
);

    localparam logic [LVL_W-1:0] LVL_MAX = '1;

    env_state_t       state_q, state_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             gate_prev;

    logic [LVL_W-1:0] sus;
    // One extra MSB on each: carry past full scale, or borrow below zero.
    logic [LVL_W:0]   att_sum;
    logic [LVL_W:0]   dec_diff;
    logic [LVL_W:0]   rel_dec;
    logic [LVL_W:0]   rel_diff;
    logic             rel_instant;

    assign sus      = {sustainLevel, {(LVL_W-15){1'b0}}};
    assign att_sum  = {1'b0, level_q} + {{(LVL_W-15){1'b0}}, attackRate};
    assign dec_diff = {1'b0, level_q} - {{(LVL_W-15){1'b0}}, decayRate};

`ifdef ENV_EXP_RELEASE_EN
    logic [11:0] unused_rel_hi;
    assign unused_rel_hi = releaseRate[15:4];
    // The +1 guarantees progress once the shifted level reaches zero;
    // shift 0 overshoots the level and so empties it in one tick.
    assign rel_dec     = {1'b0, level_q >> releaseRate[3:0]} + {{LVL_W{1'b0}}, 1'b1};
    assign rel_instant = 1'b0;
`else
    assign rel_dec     = {{(LVL_W-15){1'b0}}, releaseRate};
    assign rel_instant = (releaseRate == 16'd0);
`endif

    assign rel_diff = {1'b0, level_q} - rel_dec;

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        if (gate && !gate_prev) begin
            // Retrigger keeps the current level to avoid a click.
            state_d = ENV_ATTACK;
        end else if (!gate && (state_q == ENV_ATTACK || state_q == ENV_DECAY ||
                               state_q == ENV_SUSTAIN)) begin
            state_d = ENV_RELEASE;
        end else begin
            case (state_q)
                ENV_IDLE: begin
                    level_d = '0;
                end
                ENV_ATTACK: begin
                    if (attackRate == 16'd0 || att_sum >= {1'b0, LVL_MAX}) begin
                        level_d = LVL_MAX;
                        state_d = ENV_DECAY;
                    end else begin
                        level_d = att_sum[LVL_W-1:0];
                    end
                end
                ENV_DECAY: begin
                    // A level already at/below sustain also lands here via borrow/compare.
                    if (decayRate == 16'd0 || dec_diff[LVL_W] || dec_diff[LVL_W-1:0] <= sus) begin
                        level_d = sus;
                        state_d = ENV_SUSTAIN;
                    end else begin
                        level_d = dec_diff[LVL_W-1:0];
                    end
                end
                ENV_SUSTAIN: begin
                    level_d = sus;
                end
                ENV_RELEASE: begin
                    if (rel_instant || rel_diff[LVL_W] || rel_diff[LVL_W-1:0] == '0) begin
                        level_d = '0;
                        state_d = ENV_IDLE;
                    end else begin
                        level_d = rel_diff[LVL_W-1:0];
                    end
                end
                default: begin
                    level_d = '0;
                    state_d = ENV_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ENV_IDLE;
            level_q   <= '0;
            gate_prev <= 1'b0;
            active    <= 1'b0;
        end else if (!en) begin
            // Cleared so a note still held on re-enable starts a fresh attack.
            state_q   <= ENV_IDLE;
            level_q   <= '0;
            gate_prev <= 1'b0;
            active    <= 1'b0;
        end else if (sampleTick) begin
            state_q   <= state_d;
            level_q   <= level_d;
            gate_prev <= gate;
            active    <= (state_d != ENV_IDLE);
        end
    end

    assign volume = {2'b00, level_q[LVL_W-1 -: 15]};
    assign state  = state_q;

endmodule

// File: tb/tb_env_adsr.sv
`timescale 1ns/1ps
module tb_env_adsr;

    localparam int M_IDLE = 0, M_ATTACK = 1, M_DECAY = 2, M_SUSTAIN = 3, M_RELEASE = 4;
    localparam longint LMAX = 64'd8388607;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sampleTick = 1'b0;
    logic        en = 1'b0;
    logic        gate = 1'b0;
    logic [15:0] attackRate = '0;
    logic [15:0] decayRate = '0;
    logic [14:0] sustainLevel = '0;
    logic [15:0] releaseRate = '0;
    logic [16:0] volume;
    logic        active;
    logic [2:0]  state;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int vol;
        int st;
        bit act;
    } exp_t;
    exp_t sb[$];

    int     m_state;
    longint m_level;
    bit     m_gp;

    always #5 clk = ~clk;

    env_adsr dut (
        .clk(clk), .rst(rst), .sampleTick(sampleTick), .en(en), .gate(gate),
        .attackRate(attackRate), .decayRate(decayRate), .sustainLevel(sustainLevel),
        .releaseRate(releaseRate), .volume(volume), .active(active), .state(state)
    );

    function automatic void model_clear();
        m_state = M_IDLE;
        m_level = 0;
        m_gp = 1'b0;
    endfunction

    // Reference envelope using wide signed integers and explicit clamps.
    function automatic void model_tick();
        longint sus, nl, dec;
        sus = longint'(sustainLevel) * 256;
        if (gate && !m_gp) begin
            m_state = M_ATTACK;
        end else if (!gate && (m_state == M_ATTACK || m_state == M_DECAY || m_state == M_SUSTAIN)) begin
            m_state = M_RELEASE;
        end else begin
            case (m_state)
                M_IDLE: m_level = 0;
                M_ATTACK: begin
                    nl = m_level + longint'(attackRate);
                    if (attackRate == 0 || nl >= LMAX) begin m_level = LMAX; m_state = M_DECAY; end
                    else m_level = nl;
                end
                M_DECAY: begin
                    nl = m_level - longint'(decayRate);
                    if (decayRate == 0 || nl <= sus) begin m_level = sus; m_state = M_SUSTAIN; end
                    else m_level = nl;
                end
                M_SUSTAIN: m_level = sus;
                default: begin
`ifdef ENV_EXP_RELEASE_EN
                    dec = (m_level >> (releaseRate & 16'h000F)) + 1;
`else
                    dec = longint'(releaseRate);
`endif
                    nl = m_level - dec;
                    if (dec == 0 || nl <= 0) begin m_level = 0; m_state = M_IDLE; end
                    else m_level = nl;
                end
            endcase
        end
        m_gp = gate;
    endfunction

    // Drive one sample tick; the expected outcome is queued before the edge.
    task automatic tick_push();
        exp_t e;
        model_tick();
        e.vol = int'(m_level >> 8);
        e.st  = m_state;
        e.act = (m_state != M_IDLE);
        sb.push_back(e);
        sampleTick = 1'b1;
        @(posedge clk);
        #1;
        sampleTick = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b0; en = 1'b0; gate = 1'b0;
        #2;
        n_cmp++;
        if (volume !== '0 || state !== 3'd0 || active !== 1'b0) begin
            n_err++;
            $display("FAIL reset_init: volume=%0d state=%0d active=%0b, expected 0/0/0", volume, state, active);
        end
        @(posedge clk); #1;
        rst = 1'b1; en = 1'b1;
        model_clear();
        attackRate = 16'h1000; gate = 1'b1;
        repeat (4) begin
            tick_push();
            e = sb.pop_front();
            n_cmp++;
            if (volume !== 17'(e.vol) || state !== 3'(e.st) || active !== e.act) begin
                n_err++;
                $display("FAIL reset_attack: volume=%0d state=%0d active=%0b, expected %0d/%0d/%0b", volume, state, active, e.vol, e.st, e.act);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (volume !== '0 || state !== 3'd0 || active !== 1'b0) begin
            n_err++;
            $display("FAIL reset_async: volume=%0d state=%0d active=%0b, expected 0/0/0", volume, state, active);
        end
        @(posedge clk); #1;
        gate = 1'b0; rst = 1'b1;
        model_clear();
    endtask

    task automatic test_full_adsr();
        exp_t e;
        int max_tick, rel;
        attackRate = 16'h8000; decayRate = 16'h4000;
        sustainLevel = 15'd16384; releaseRate = 16'h2000;
        gate = 1'b1;
        max_tick = -1;
        for (int t = 1; t <= 600; t++) begin
            tick_push();
            e = sb.pop_front();
            n_cmp++;
            if (volume !== 17'(e.vol) || state !== 3'(e.st) || active !== e.act) begin
                n_err++;
                $display("FAIL adsr_tick%0d: volume=%0d state=%0d active=%0b, expected %0d/%0d/%0b", t, volume, state, active, e.vol, e.st, e.act);
            end
            if (max_tick < 0 && volume == 17'd32767) max_tick = t;
            if (t == 100) begin
                repeat (4) @(posedge clk);
                #1;
                n_cmp++;
                if (volume !== 17'(m_level >> 8) || state !== 3'(M_ATTACK)) begin
                    n_err++;
                    $display("FAIL hold_between_ticks: volume=%0d state=%0d, expected %0d/%0d", volume, state, m_level >> 8, M_ATTACK);
                end
            end
        end
        // Edge tick enters ATTACK, then 256 steps of 0x8000 reach full scale.
        n_cmp++;
        if (max_tick !== 257) begin
            n_err++;
            $display("FAIL attack_peak_tick: got %0d, expected 257", max_tick);
        end
        n_cmp++;
        if (volume !== 17'd16384 || state !== 3'(M_SUSTAIN)) begin
            n_err++;
            $display("FAIL sustain_level: volume=%0d state=%0d, expected 16384/3", volume, state);
        end
        gate = 1'b0;
        rel = 0;
        tick_push();
        e = sb.pop_front();
        n_cmp++;
        if (volume !== 17'(e.vol) || state !== 3'(e.st) || active !== e.act) begin
            n_err++;
            $display("FAIL release_entry: volume=%0d state=%0d active=%0b, expected %0d/%0d/%0b", volume, state, active, e.vol, e.st, e.act);
        end
        while (state !== 3'd0 && rel < 2000) begin
            tick_push();
            e = sb.pop_front();
            rel++;
            n_cmp++;
            if (volume !== 17'(e.vol) || state !== 3'(e.st) || active !== e.act) begin
                n_err++;
                $display("FAIL release_tick%0d: volume=%0d state=%0d active=%0b, expected %0d/%0d/%0b", rel, volume, state, active, e.vol, e.st, e.act);
            end
        end
        n_cmp++;
`ifdef ENV_EXP_RELEASE_EN
        if (rel !== 1) begin
            n_err++;
            $display("FAIL release_length: got %0d ticks, expected 1", rel);
        end
`else
        if (rel !== 512) begin
            n_err++;
            $display("FAIL release_length: got %0d ticks, expected 512", rel);
        end
`endif
    endtask

    task automatic test_zero_rates();
        exp_t e;
        attackRate = '0; decayRate = '0; releaseRate = '0;
        sustainLevel = 15'd1000;
        gate = 1'b1;
        for (int t = 0; t < 3; t++) begin
            tick_push();
            e = sb.pop_front();
            n_cmp++;
            if (volume !== 17'(e.vol) || state !== 3'(e.st) || active !== e.act) begin
                n_err++;
                $display("FAIL zero_tick%0d: volume=%0d state=%0d active=%0b, expected %0d/%0d/%0b", t, volume, state, active, e.vol, e.st, e.act);
            end
            if (t == 1) begin
                n_cmp++;
                if (volume !== 17'd32767) begin
                    n_err++;
                    $display("FAIL zero_attack: volume=%0d, expected 32767", volume);
                end
            end
        end
        n_cmp++;
        if (volume !== 17'd1000 || state !== 3'(M_SUSTAIN)) begin
            n_err++;
            $display("FAIL zero_decay: volume=%0d state=%0d, expected 1000/3", volume, state);
        end
        gate = 1'b0;
        repeat (2) begin
            tick_push();
            e = sb.pop_front();
            n_cmp++;
            if (volume !== 17'(e.vol) || state !== 3'(e.st) || active !== e.act) begin
                n_err++;
                $display("FAIL zero_release: volume=%0d state=%0d active=%0b, expected %0d/%0d/%0b", volume, state, active, e.vol, e.st, e.act);
            end
        end
        n_cmp++;
        if (volume !== '0 || state !== 3'(M_IDLE) || active !== 1'b0) begin
            n_err++;
            $display("FAIL zero_idle: volume=%0d state=%0d active=%0b, expected 0/0/0", volume, state, active);
        end
    endtask

    task automatic test_retrigger();
        exp_t e;
        attackRate = '0; decayRate = '0; releaseRate = 16'h000F;
        sustainLevel = 15'd8000;
        gate = 1'b1;
        for (int t = 0; t < 6; t++) begin
            if (t == 3) gate = 1'b0;
            if (t == 4) begin gate = 1'b1; attackRate = 16'h0100; end
            tick_push();
            e = sb.pop_front();
            n_cmp++;
            if (volume !== 17'(e.vol) || state !== 3'(e.st) || active !== e.act) begin
                n_err++;
                $display("FAIL retrig_tick%0d: volume=%0d state=%0d active=%0b, expected %0d/%0d/%0b", t, volume, state, active, e.vol, e.st, e.act);
            end
            if (t == 3) begin
                n_cmp++;
                if (volume !== 17'd8000 || state !== 3'(M_RELEASE)) begin
                    n_err++;
                    $display("FAIL retrig_release: volume=%0d state=%0d, expected 8000/4", volume, state);
                end
            end
            if (t == 4) begin
                n_cmp++;
                if (volume !== 17'd8000 || state !== 3'(M_ATTACK)) begin
                    n_err++;
                    $display("FAIL retrig_keep_level: volume=%0d state=%0d, expected 8000/1", volume, state);
                end
            end
        end
        n_cmp++;
        if (volume !== 17'd8001) begin
            n_err++;
            $display("FAIL retrig_continue: volume=%0d, expected 8001", volume);
        end
        en = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (volume !== '0 || state !== 3'(M_IDLE) || active !== 1'b0) begin
            n_err++;
            $display("FAIL en_low: volume=%0d state=%0d active=%0b, expected 0/0/0", volume, state, active);
        end
        gate = 1'b0; en = 1'b1;
        model_clear();
        tick_push();
        e = sb.pop_front();
        n_cmp++;
        if (volume !== 17'(e.vol) || state !== 3'(e.st) || active !== e.act) begin
            n_err++;
            $display("FAIL en_restore: volume=%0d state=%0d active=%0b, expected %0d/%0d/%0b", volume, state, active, e.vol, e.st, e.act);
        end
    endtask

    task automatic test_saturation();
        exp_t e;
        attackRate = '0; decayRate = 16'd10; releaseRate = '0;
        sustainLevel = '0;
        gate = 1'b1;
        // edge, full scale, full scale - 10, release entry, retrigger, attack 0xFFFF
        for (int t = 0; t < 6; t++) begin
            if (t == 3) gate = 1'b0;
            if (t == 4) begin gate = 1'b1; attackRate = 16'hFFFF; end
            tick_push();
            e = sb.pop_front();
            n_cmp++;
            if (volume !== 17'(e.vol) || state !== 3'(e.st) || active !== e.act) begin
                n_err++;
                $display("FAIL sat_tick%0d: volume=%0d state=%0d active=%0b, expected %0d/%0d/%0b", t, volume, state, active, e.vol, e.st, e.act);
            end
        end
        n_cmp++;
        if (volume !== 17'd32767 || state !== 3'(M_DECAY)) begin
            n_err++;
            $display("FAIL sat_clamp: volume=%0d state=%0d, expected 32767/2", volume, state);
        end
        sustainLevel = 15'd32767; decayRate = 16'h4000;
        tick_push();
        e = sb.pop_front();
        n_cmp++;
        if (volume !== 17'(e.vol) || state !== 3'(e.st) || active !== e.act) begin
            n_err++;
            $display("FAIL sat_decay_tick: volume=%0d state=%0d active=%0b, expected %0d/%0d/%0b", volume, state, active, e.vol, e.st, e.act);
        end
        n_cmp++;
        if (volume !== 17'd32767 || state !== 3'(M_SUSTAIN)) begin
            n_err++;
            $display("FAIL sat_sustain_exit: volume=%0d state=%0d, expected 32767/3", volume, state);
        end
    endtask

    task automatic test_release_shape();
        exp_t e;
        int prev, n;
        bit mono;
        releaseRate = 16'h0004;
        gate = 1'b0;
        tick_push();
        e = sb.pop_front();
        n_cmp++;
        if (volume !== 17'(e.vol) || state !== 3'(e.st) || active !== e.act) begin
            n_err++;
            $display("FAIL shape_entry: volume=%0d state=%0d active=%0b, expected %0d/%0d/%0b", volume, state, active, e.vol, e.st, e.act);
        end
`ifdef ENV_EXP_RELEASE_EN
        prev = 32767; n = 0; mono = 1'b1;
        while (state !== 3'd0 && n < 2000) begin
            tick_push();
            e = sb.pop_front();
            n++;
            n_cmp++;
            if (volume !== 17'(e.vol) || state !== 3'(e.st) || active !== e.act) begin
                n_err++;
                $display("FAIL exp_tick%0d: volume=%0d state=%0d active=%0b, expected %0d/%0d/%0b", n, volume, state, active, e.vol, e.st, e.act);
            end
            if (int'(volume) > prev) mono = 1'b0;
            prev = int'(volume);
        end
        n_cmp++;
        if (!mono || state !== 3'(M_IDLE) || volume !== '0) begin
            n_err++;
            $display("FAIL exp_tail: monotonic=%0b state=%0d volume=%0d, expected 1/0/0", mono, state, volume);
        end
`else
        mono = 1'b1;
        prev = 0;
        for (n = 0; n < 512; n++) begin
            tick_push();
            e = sb.pop_front();
            n_cmp++;
            if (volume !== 17'(e.vol) || state !== 3'(e.st) || active !== e.act) begin
                n_err++;
                $display("FAIL lin_tick%0d: volume=%0d state=%0d active=%0b, expected %0d/%0d/%0b", n, volume, state, active, e.vol, e.st, e.act);
            end
        end
        n_cmp++;
        if (volume !== 17'd32759 || state !== 3'(M_RELEASE)) begin
            n_err++;
            $display("FAIL lin_ramp: volume=%0d state=%0d, expected 32759/4", volume, state);
        end
        releaseRate = '0;
        tick_push();
        e = sb.pop_front();
        n_cmp++;
        if (volume !== '0 || state !== 3'(M_IDLE) || 17'(e.vol) !== '0) begin
            n_err++;
            $display("FAIL lin_instant: volume=%0d state=%0d, expected 0/0 (model %0d)", volume, state, e.vol);
        end
`endif
    endtask

    initial begin
        model_clear();
        test_reset();
        test_full_adsr();
        test_zero_rates();
        test_retrigger();
        test_saturation();
        test_release_shape();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
